// File: rtl/sram_pkg.sv
// Shared types, widths and half-select constants for the DE2 SRAM bridge.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DQ_W   = 16;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LO_SETUP,
        LO_STRB,
        HI_SETUP,
        HI_STRB,
        DONE
    } sram_state_e;

endpackage

// File: rtl/sram_io_buf.sv
// SRAM data pad: tri-state write driver plus registered capture of read halves.
module sram_io_buf
    import sram_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     oe_i,
    input  logic [SRAM_DQ_W-1:0]     wdata_i,
    input  logic                     ld_lo_i,
    input  logic                     ld_hi_i,
    inout  wire  [SRAM_DQ_W-1:0]     dq_io,
    output logic [2*SRAM_DQ_W-1:0]   rdata_o
);

    logic [2*SRAM_DQ_W-1:0] rdata_q, rdata_d;

    assign dq_io = oe_i ? wdata_i : {SRAM_DQ_W{1'bz}};

    always_comb begin
        rdata_d = rdata_q;
        if (ld_lo_i) rdata_d[SRAM_DQ_W-1:0]           = dq_io;
        if (ld_hi_i) rdata_d[2*SRAM_DQ_W-1:SRAM_DQ_W] = dq_io;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit core data port to 16-bit async SRAM bridge; each access runs a LO then HI halfword phase.
// Define SRAM_CTRL_HALF_SKIP_EN to skip write halves whose two byte enables are both clear.
//
// state    | meaning
// IDLE     | ready for a request, bus released
// LO_SETUP | low halfword address/data/lanes presented
// LO_STRB  | low halfword strobe (WE_N low on writes), WAIT_CYCLES long
// HI_SETUP | high halfword address/data/lanes presented
// HI_STRB  | high halfword strobe, WAIT_CYCLES long
// DONE     | completion pulse, bus released for turnaround
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic                     i_we,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_bmask,
    output logic                     o_ready,
    output logic                     o_done,
    output logic [31:0]              o_rdata,
    output logic [SRAM_ADDR_W-1:0]   o_SRAM_ADDR,
    inout  wire  [SRAM_DQ_W-1:0]     io_SRAM_DQ,
    output logic                     o_SRAM_WE_N,
    output logic                     o_SRAM_OE_N,
    output logic                     o_SRAM_CE_N,
    output logic                     o_SRAM_UB_N,
    output logic                     o_SRAM_LB_N
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [16:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        bmask_q;
    logic              accept;
    logic              ld_lo, ld_hi;
    logic              phase_lo, phase_hi, phase_act, strobe;
    logic [1:0]        lane_en;
    logic              dq_oe;
    logic [SRAM_DQ_W-1:0] dq_wdata;
    logic              unused_addr;

    assign unused_addr = ^{i_addr[31:19], i_addr[1:0]};
    assign accept      = i_req && (state_q == IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= i_we;
                addr_q  <= i_addr[18:2];
                wdata_q <= i_wdata;
                bmask_q <= i_bmask;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_lo   = 1'b0;
        ld_hi   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = LO_SETUP;
`ifdef SRAM_CTRL_HALF_SKIP_EN
                    if (i_we && (i_bmask[1:0] == 2'b00))
                        state_d = (i_bmask[3:2] == 2'b00) ? DONE : HI_SETUP;
`endif
                end
            end
            LO_SETUP: begin
                state_d = LO_STRB;
                cnt_d   = CNT_LOAD;
            end
            LO_STRB: begin
                if (cnt_q == '0) begin
                    ld_lo   = !we_q;
                    state_d = HI_SETUP;
`ifdef SRAM_CTRL_HALF_SKIP_EN
                    if (we_q && (bmask_q[3:2] == 2'b00)) state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HI_SETUP: begin
                state_d = HI_STRB;
                cnt_d   = CNT_LOAD;
            end
            HI_STRB: begin
                if (cnt_q == '0) begin
                    ld_hi   = !we_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin controls decode straight from registers so reset releases them asynchronously.
    assign phase_lo  = (state_q == LO_SETUP) || (state_q == LO_STRB);
    assign phase_hi  = (state_q == HI_SETUP) || (state_q == HI_STRB);
    assign phase_act = phase_lo || phase_hi;
    assign strobe    = (state_q == LO_STRB) || (state_q == HI_STRB);
    assign lane_en   = !we_q ? 2'b11 : (phase_hi ? bmask_q[3:2] : bmask_q[1:0]);
    assign dq_oe     = phase_act && we_q;
    assign dq_wdata  = phase_hi ? wdata_q[31:16] : wdata_q[15:0];

    assign o_SRAM_ADDR = {addr_q, phase_hi ? HALF_HI : HALF_LO};
    assign o_SRAM_CE_N = !phase_act;
    assign o_SRAM_OE_N = !(phase_act && !we_q);
    assign o_SRAM_WE_N = !(strobe && we_q);
    assign o_SRAM_LB_N = !(phase_act && lane_en[0]);
    assign o_SRAM_UB_N = !(phase_act && lane_en[1]);
    assign o_ready     = (state_q == IDLE);
    assign o_done      = (state_q == DONE);

    sram_io_buf u_io (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .oe_i    (dq_oe),
        .wdata_i (dq_wdata),
        .ld_lo_i (ld_lo),
        .ld_hi_i (ld_hi),
        .dq_io   (io_SRAM_DQ),
        .rdata_o (o_rdata)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural SRAM chip and a word-level reference memory.
module tb_sram_ctrl;

    localparam int W     = 1;
    localparam int NHALF = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  bmask = '0;
    logic        ready, done;
    logic [31:0] rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int checks = 0;
    int passes = 0;

    logic [15:0] sram_mem [NHALF];
    logic [15:0] ref_mem  [NHALF];
    logic [35:0] prev_bus = '0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_bmask(bmask), .o_ready(ready), .o_done(done),
        .o_rdata(rdata), .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
        .o_SRAM_WE_N(we_n), .o_SRAM_OE_N(oe_n), .o_SRAM_CE_N(ce_n),
        .o_SRAM_UB_N(ub_n), .o_SRAM_LB_N(lb_n)
    );

    // Behavioural async SRAM chip
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'bz;

    always @(negedge clk) begin
        if (!rst && !we_n) begin
            checks++;
            if ({sram_addr, ub_n, lb_n, sram_dq} !== prev_bus)
                $display("FAIL write_setup: bus %h at WE_N low, prior cycle %h",
                         {sram_addr, ub_n, lb_n, sram_dq}, prev_bus);
            else passes++;
            if (!ce_n) begin
                if (!lb_n) sram_mem[sram_addr][7:0]  = sram_dq[7:0];
                if (!ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
            end
        end
        prev_bus = {sram_addr, ub_n, lb_n, sram_dq};
    end

    // Reference: word byte b lives in halfword (2*word + b/2), lane b%2
    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm);
        int ha;
        ha = int'(a[18:2]) * 2;
        for (int b = 0; b < 4; b++)
            if (bm[b]) ref_mem[ha + b/2][8*(b%2) +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int ha;
        ha = int'(a[18:2]) * 2;
        return {ref_mem[ha + 1], ref_mem[ha]};
    endfunction

    function automatic int exp_lat(input bit w, input logic [3:0] bm);
`ifdef SRAM_CTRL_HALF_SKIP_EN
        if (w) return ((bm[1:0] != 0 ? 1 : 0) + (bm[3:2] != 0 ? 1 : 0)) * (W + 1) + 1;
`endif
        return 2 * (W + 1) + 1;
    endfunction

    task automatic do_access(input bit a_we, input logic [31:0] a_addr, input logic [31:0] a_wd,
                             input logic [3:0] a_bm, output int lat, output logic [31:0] rd,
                             output bit lo_seen, output bit lo_lane,
                             output logic [17:0] lo_addr, output logic [17:0] hi_addr);
        int n;
        bit lo_got, hi_got;
        lat = -1; rd = '0; lo_seen = 0; lo_lane = 0; lo_addr = '1; hi_addr = '1;
        lo_got = 0; hi_got = 0;
        @(negedge clk);
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            checks++;
            $display("FAIL ready_wait: o_ready=%b after 50 cycles, want 1", ready);
            return;
        end
        req = 1; we = a_we; addr = a_addr; wdata = a_wd; bmask = a_bm;
        if (a_we) ref_write(a_addr, a_wd, a_bm);
        @(posedge clk);
        #1;
        req = 0; we = $urandom; addr = $urandom; wdata = $urandom; bmask = 4'($urandom);
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (!ce_n) begin
                if (!sram_addr[0]) begin
                    lo_seen = 1;
                    if (!ub_n || !lb_n) lo_lane = 1;
                    if (!lo_got) begin lo_addr = sram_addr; lo_got = 1; end
                end else if (!hi_got) begin
                    hi_addr = sram_addr; hi_got = 1;
                end
            end
            if (done) begin lat = n; rd = rdata; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111)
            $display("FAIL reset_ctrl: controls %b, want 11111", {we_n, oe_n, ce_n, ub_n, lb_n}); else passes++;
        checks++; if (ready !== 1'b1 || done !== 1'b0)
            $display("FAIL reset_hs: ready %b done %b, want 1 0", ready, done); else passes++;
        checks++; if (rdata !== 32'h0 || sram_addr !== 18'h0)
            $display("FAIL reset_data: rdata %h addr %h, want 0 0", rdata, sram_addr); else passes++;
        checks++; if (dut.dq_oe !== 1'b0)
            $display("FAIL reset_dq: dq drive %b, want 0 (tri-state)", dut.dq_oe); else passes++;
        rst = 0;
    endtask

    task automatic test_round_trip();
        int lat; logic [31:0] rd; bit ls, ll; logic [17:0] la, ha;
        do_access(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, ls, ll, la, ha);
        checks++; if (lat !== 5)
            $display("FAIL rt_wr_latency: done at cycle %0d, want 5", lat); else passes++;
        checks++; if ({sram_mem[9], sram_mem[8]} !== 32'hDEAD_BEEF)
            $display("FAIL rt_wr_mem: mem[9:8] %h, want deadbeef", {sram_mem[9], sram_mem[8]}); else passes++;
        do_access(0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, ls, ll, la, ha);
        checks++; if (rd !== 32'hDEAD_BEEF)
            $display("FAIL rt_rd_data: rdata %h, want deadbeef", rd); else passes++;
        checks++; if (lat !== 5)
            $display("FAIL rt_rd_latency: done at cycle %0d, want 5", lat); else passes++;
    endtask

    task automatic test_byte_mask();
        int lat; logic [31:0] rd; bit ls, ll; logic [17:0] la, ha;
        do_access(1, 32'h0000_0010, 32'h1122_3344, 4'b0100, lat, rd, ls, ll, la, ha);
        checks++; if ({sram_mem[9], sram_mem[8]} !== 32'hDE22_BEEF)
            $display("FAIL bm_mem: mem[9:8] %h, want de22beef", {sram_mem[9], sram_mem[8]}); else passes++;
        checks++; if (lat !== exp_lat(1, 4'b0100))
            $display("FAIL bm_latency: done at cycle %0d, want %0d", lat, exp_lat(1, 4'b0100)); else passes++;
`ifdef SRAM_CTRL_HALF_SKIP_EN
        checks++; if (ls !== 1'b0)
            $display("FAIL bm_lo_skip: LO phase seen %b, want 0", ls); else passes++;
`else
        checks++; if (ls !== 1'b1 || ll !== 1'b0)
            $display("FAIL bm_lo_lanes: LO seen %b lanes active %b, want 1 0", ls, ll); else passes++;
`endif
    endtask

    task automatic test_aliasing();
        int lat; logic [31:0] rd; bit ls, ll; logic [17:0] la, ha;
        do_access(0, 32'h0008_0010, 32'h0, 4'h0, lat, rd, ls, ll, la, ha);
        checks++; if (rd !== ref_read(32'h0000_0010))
            $display("FAIL alias_data: rdata %h, want %h", rd, ref_read(32'h0000_0010)); else passes++;
        checks++; if (la !== 18'h00008 || ha !== 18'h00009)
            $display("FAIL alias_addr: addrs %h/%h, want 00008/00009", la, ha); else passes++;
    endtask

    task automatic test_busy_ignored();
        logic [31:0] a_a, a_b;
        int n; bit found;
        a_a = 32'h0000_0040; a_b = 32'h0000_0088;
        @(negedge clk);
        req = 1; we = 1; addr = a_a; wdata = $urandom; bmask = 4'hF;
        ref_write(a_a, wdata, 4'hF);
        @(posedge clk);
        #1 req = 0;
        found = 0;
        for (n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (!ce_n && sram_addr[0]) found = 1;
        end
        checks++; if (!found) $display("FAIL busy_hi_setup: HI phase seen %b, want 1", found); else passes++;
        req = 1; we = 0; addr = a_b;
        n = 0;
        while (!done && n < 20) begin
            checks++; if (sram_addr[17:1] !== a_a[18:2])
                $display("FAIL busy_addr: halfword pair %h, want %h", sram_addr[17:1], a_a[18:2]); else passes++;
            @(negedge clk); n++;
        end
        checks++; if (done !== 1'b1) $display("FAIL busy_done: o_done %b, want 1", done); else passes++;
        @(negedge clk);
        checks++; if (ready !== 1'b1) $display("FAIL busy_ready: o_ready %b, want 1", ready); else passes++;
        @(negedge clk);
        checks++; if (ce_n !== 1'b0 || sram_addr !== {a_b[18:2], 1'b0})
            $display("FAIL busy_accept: ce_n %b addr %h, want 0 %h", ce_n, sram_addr, {a_b[18:2], 1'b0}); else passes++;
        req = 0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        checks++; if (rdata !== ref_read(a_b))
            $display("FAIL busy_rdata: rdata %h, want %h", rdata, ref_read(a_b)); else passes++;
    endtask

    task automatic test_back_to_back();
        int stamps[$];
        @(negedge clk);
        we = 0; addr = 32'h0000_0010; req = 1;
        for (int c = 0; c < 60; c++) begin
            if (ready) begin
                stamps.push_back(c);
                if (stamps.size() == 3) begin req = 0; break; end
            end
            @(negedge clk);
        end
        req = 0;
        checks++; if (stamps.size() != 3)
            $display("FAIL b2b_count: %0d accepts, want 3", stamps.size()); else passes++;
        for (int i = 1; i < stamps.size(); i++) begin
            checks++; if (stamps[i] - stamps[i-1] != 2 * (W + 1) + 2)
                $display("FAIL b2b_period: %0d cycles, want %0d", stamps[i] - stamps[i-1], 2 * (W + 1) + 2);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, d;
        int n; bit done_seen;
        a = 32'h0000_0100; d = $urandom;
        @(negedge clk);
        req = 1; we = 1; addr = a; wdata = d; bmask = 4'hF;
        @(posedge clk);
        #1 req = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (we_n && n < 10);
        checks++; if (we_n !== 1'b0) $display("FAIL rmid_strobe: we_n %b, want 0", we_n); else passes++;
        ref_write(a, d, 4'b0011);
        #2 rst = 1;
        #1;
        checks++; if ({we_n, ce_n, oe_n} !== 3'b111)
            $display("FAIL rmid_async: we_n/ce_n/oe_n %b, want 111", {we_n, ce_n, oe_n}); else passes++;
        done_seen = 0;
        repeat (2) begin @(negedge clk); if (done) done_seen = 1; end
        rst = 0;
        repeat (6) begin @(negedge clk); if (done) done_seen = 1; end
        checks++; if (done_seen) $display("FAIL rmid_no_done: o_done seen %b, want 0", done_seen); else passes++;
        checks++; if (sram_mem[int'(a[18:2]) * 2 + 1] !== ref_mem[int'(a[18:2]) * 2 + 1])
            $display("FAIL rmid_hi_kept: hi %h, want %h", sram_mem[int'(a[18:2]) * 2 + 1],
                     ref_mem[int'(a[18:2]) * 2 + 1]); else passes++;
        checks++; if (rdata !== 32'h0 || ready !== 1'b1)
            $display("FAIL rmid_state: rdata %h ready %b, want 0 1", rdata, ready); else passes++;
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; bit ls, ll; logic [17:0] la, ha;
        logic [31:0] a, d; logic [3:0] bm; bit w; int h;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[18:2] = 17'h100 + 17'($urandom_range(0, 15));
            d = $urandom; bm = 4'($urandom); w = 1'($urandom);
            h = int'(a[18:2]) * 2;
            do_access(w, a, d, bm, lat, rd, ls, ll, la, ha);
            checks++; if (lat !== exp_lat(w, bm))
                $display("FAIL rnd_latency: op %0d done at %0d, want %0d", i, lat, exp_lat(w, bm)); else passes++;
            if (w) begin
                checks++; if ({sram_mem[h + 1], sram_mem[h]} !== {ref_mem[h + 1], ref_mem[h]})
                    $display("FAIL rnd_wr_mem: op %0d mem %h, want %h", i, {sram_mem[h + 1], sram_mem[h]},
                             {ref_mem[h + 1], ref_mem[h]}); else passes++;
            end else begin
                checks++; if (rd !== ref_read(a))
                    $display("FAIL rnd_rd_data: op %0d rdata %h, want %h", i, rd, ref_read(a)); else passes++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NHALF; i++) begin
            sram_mem[i] = 16'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        test_reset();
        test_round_trip();
        test_byte_mask();
        test_aliasing();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Bridges the RISC-V core's 32-bit data-memory request port to the 16-bit asynchronous off-chip SRAM (256K x 16) on the DE2 board. It sits directly below the core's load/store path and drives the board SRAM pins. Each 32-bit access is split into two sequenced 16-bit half-accesses: low halfword first, then high. A valid/ready handshake is used toward the core.

## Interface
- WAIT_CYCLES, default 1: strobe cycles per half-access. Minimum 1.
- i_clk  in  1  system clock (CLOCK_50).
- i_rst  in  1  reset. Asynchronous, active-high.
- i_req  in  1  request valid.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  32  byte address. Only [18:2] is used; [1:0] and [31:19] are ignored, so addresses alias.
- i_wdata  in  32  write data.
- i_bmask  in  4  byte enables for writes. Ignored for reads.
- o_ready  out  1  controller idle; a request is accepted this cycle.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  read data. Updated only when a read completes; held otherwise.
- o_SRAM_ADDR  out  18  SRAM halfword address.
- io_SRAM_DQ  inout  16  SRAM data bus.
- o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_CE_N, o_SRAM_UB_N, o_SRAM_LB_N  out  1 each  active-low SRAM controls.

## Operation
- **Handshake:** a request is accepted at the rising edge where i_req && o_ready.
  - i_we, i_addr, i_wdata and i_bmask are registered at that edge; the inputs may change afterwards.
  - i_req while busy is ignored and not queued.
- **FSM states:** IDLE, LO_SETUP, LO_STRB, HI_SETUP, HI_STRB, DONE.
  - IDLE -> LO_SETUP on accept.
  - LO_SETUP -> LO_STRB.
  - LO_STRB -> HI_SETUP after WAIT_CYCLES cycles.
  - HI_SETUP -> HI_STRB.
  - HI_STRB -> DONE after WAIT_CYCLES cycles.
  - DONE -> IDLE.
- **Address:** o_SRAM_ADDR = {i_addr[18:2], 0} during the LO phase and {i_addr[18:2], 1} during the HI phase.
- **Write, LO phase:**
  - DQ driven with wdata[15:0].
  - LB_N = ~bmask[0], UB_N = ~bmask[1].
  - WE_N low only in LO_STRB.
- **Write, HI phase:** same as LO, using wdata[31:16], bmask[2], bmask[3].
- **Read:**
  - OE_N low and UB_N/LB_N low in all four phase states; DQ is tri-stated.
  - DQ is captured into rdata[15:0] at the edge ending LO_STRB, and into rdata[31:16] at the edge ending HI_STRB.
- **Chip enable:** CE_N is low in every non-IDLE, non-DONE state.
- **DQ drive:** DQ is driven only in write SETUP/STRB states. It is tri-stated in IDLE, in DONE and for all reads. Passing through IDLE/DONE guarantees at least 2 cycles of bus turnaround between a read and a write.
- **Completion:** o_done = 1 in DONE only; o_ready = 1 in IDLE only.

## Timing
- **Reset values:**
  - state = IDLE, o_ready = 1, o_done = 0, o_rdata = 0, o_SRAM_ADDR = 0.
  - WE_N, OE_N, CE_N, UB_N, LB_N all = 1.
  - DQ tri-stated.
- **Latency:** with the accept edge as cycle 0, o_done is high in cycle 2*(WAIT_CYCLES+1)+1, which is cycle 5 for WAIT_CYCLES = 1. o_ready returns in the following cycle.
- **Throughput:** one access per 2*(WAIT_CYCLES+1)+2 cycles.
- **Setup/hold:** address, data and UB/LB are stable one cycle before WE_N falls and remain stable through the edge where WE_N rises.
- **Reset mid-operation:** all controls are forced inactive immediately (asynchronously) and no o_done is issued. A half already strobed stays written; this is accepted behaviour.
- **bmask = 0 write:** completes normally with UB_N/LB_N both high throughout, unless the skip feature below is enabled.

## Configuration
- Macro: SRAM_CTRL_HALF_SKIP_EN.
- **Defined:** a write half whose two mask bits are both 0 skips its SETUP/STRB states.
  - LO-only write: LO_STRB -> DONE.
  - HI-only write: IDLE -> HI_SETUP.
  - bmask = 0: IDLE -> DONE. o_done appears in cycle 1 and no strobe occurs.
  - Reads always run both halves.
- **Undefined:** both halves always run; latency is fixed.

## Structure
- **Package sram_pkg** holds:
  - typedef enum sram_state_e;
  - SRAM_ADDR_W = 18 and SRAM_DQ_W = 16;
  - half-select constants HALF_LO = 0 and HALF_HI = 1.
- **Sub-module sram_io_buf:**
  - tri-state driver for io_SRAM_DQ (output-enable plus output data);
  - registered capture of the input, with load strobes for the low and high rdata halves.

## Test plan
- **Reset state:** hold i_rst high -> all SRAM controls = 1, DQ = Z, o_ready = 1, o_rdata = 0.
- **Write/read round trip:** write addr 0x0000_0010, data 0xDEAD_BEEF, bmask 0xF (WAIT_CYCLES = 1) -> SRAM model holds 0xBEEF at halfword 0x00008 and 0xDEAD at 0x00009; o_done in cycle 5. A following read of the same address -> o_rdata = 0xDEAD_BEEF.
- **Byte mask:** write 0x1122_3344 with bmask 0b0100 -> only the UB=1/LB=0 half at 0x00009 changes its low byte to 0x22. Without the macro, the LO phase occurs with UB_N = LB_N = 1. With the macro, o_done comes at cycle 3.
- **Reset during LO_STRB:** assert i_rst during a write in LO_STRB -> WE_N goes high in the same cycle, no o_done, HI half unchanged.
- **Busy request ignored:** assert i_req during HI_SETUP with a different address -> it is not accepted; it is accepted on the cycle after DONE.
- **Address aliasing:** read addr 0x0008_0010 -> same data as 0x0000_0010; o_SRAM_ADDR = 0x00008 then 0x00009.
